// File: rtl/dpram_stream_fifo_pkg.sv
// Shared sizes for the RAM-backed stream FIFO and its skid output stage.
package dpram_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DEPTH          = 2**ADDR_WIDTH_DEF;
  localparam int PTR_WIDTH      = ADDR_WIDTH_DEF + 1;
  localparam int COUNT_WIDTH    = ADDR_WIDTH_DEF + 1;
  localparam int SKID_DEPTH     = 2;
  localparam int SKID_CNT_W     = $clog2(SKID_DEPTH + 1);

  typedef logic [PTR_WIDTH-1:0]   ptr_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;
endpackage

// File: rtl/dpram_stream_fifo_if.sv
// Valid/ready stream pair seen by the FIFO: producer side in, consumer side out.
interface dpram_stream_fifo_if
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/dpram_skid2.sv
// Two-entry register FIFO that absorbs RAM read data; head register drives the consumer.
module dpram_skid2
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [SKID_CNT_W-1:0] skid_count
);
  localparam logic [SKID_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [SKID_CNT_W-1:0] CNT_ONE  = SKID_CNT_W'(1);
  localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] tail_data;
  logic [SKID_CNT_W-1:0] cnt_next;
  logic                  pop_ok;

  assign pop_ok = pop && head_valid;

  always_comb begin
    cnt_next = skid_count;
    if (push && !pop_ok)
      cnt_next = skid_count + CNT_ONE;
    else if (!push && pop_ok)
      cnt_next = skid_count - CNT_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_count <= CNT_ZERO;
      head_valid <= 1'b0;
    end else if (clear) begin
      skid_count <= CNT_ZERO;
      head_valid <= 1'b0;
    end else begin
      skid_count <= cnt_next;
      head_valid <= (cnt_next != CNT_ZERO);
    end
  end

  // Data registers carry no reset; occupancy alone says what is meaningful.
  always_ff @(posedge clock) begin
    if (push && (skid_count == CNT_ZERO || (pop_ok && skid_count == CNT_ONE)))
      head_data <= push_data;
    else if (pop_ok && skid_count == CNT_FULL)
      head_data <= tail_data;
    if (push && ((skid_count == CNT_ONE && !pop_ok) || (skid_count == CNT_FULL && pop_ok)))
      tail_data <= push_data;
  end

  a_no_push_when_full : assert property (@(posedge clock) disable iff (reset)
    !(push && !clear && !pop_ok && skid_count == CNT_FULL));
endmodule

// File: rtl/dpram_stream_fifo.sv
// Stream FIFO controller: writes accepted words to RAM port a, reads port b into a skid stage.
module dpram_stream_fifo
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  dpram_stream_fifo_if.slave    stream,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, used;
  logic                  ram_full, ram_avail, accept, issue, pop, credit_ok;
  logic                  rd_vld_p1;
  logic [ADDR_WIDTH-1:0] rd_addr_p1;
  logic [SKID_CNT_W-1:0] skid_count;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_valid;
  logic [CW-1:0]         skid_next, occ_next;

  function automatic logic [ADDR_WIDTH:0] sat_count(input logic [CW-1:0] v);
    return v[CW-1] ? {(ADDR_WIDTH+1){1'b1}} : v[ADDR_WIDTH:0];
  endfunction

  assign used            = wr_ptr - rd_ptr;
  assign ram_full        = (used == RAM_DEPTH);
  assign ram_avail       = (wr_ptr != rd_ptr);

  assign stream.in_ready = !ram_full && !reset;
  assign accept          = stream.in_valid && stream.in_ready && !clear;
  assign ram_we_a        = accept;
  assign ram_addr_a      = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_data_a      = stream.in_data;

  // A read may issue only if the skid stage is guaranteed room when its data lands.
  assign pop       = head_valid && stream.out_ready;
  assign credit_ok = (3'(skid_count) + 3'(rd_vld_p1)) < (3'd2 + 3'(pop));
  assign issue     = ram_avail && credit_ok && !clear;

  assign ram_addr_b = issue ? rd_ptr[ADDR_WIDTH-1:0] : rd_addr_p1;
  assign ram_data_b = '0;
  assign ram_we_b   = 1'b0;

  assign wr_ptr_next = wr_ptr + PW'(accept);
  assign rd_ptr_next = rd_ptr + PW'(issue);
  assign skid_next   = CW'(skid_count) + CW'(rd_vld_p1) - CW'(pop);
  assign occ_next    = CW'(wr_ptr_next - rd_ptr_next) + CW'(issue) + skid_next;

  // Stage p0 -> p1: pointer update and read issue; RAM registers q_b meanwhile.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_vld_p1 <= 1'b0;
      count     <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_vld_p1 <= 1'b0;
      count     <= '0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      rd_vld_p1 <= issue;
      count     <= sat_count(occ_next);
    end
  end

  always_ff @(posedge clock) begin
    if (issue)
      rd_addr_p1 <= rd_ptr[ADDR_WIDTH-1:0];
  end

  // Stage p1 -> p2: returned RAM word enters the skid stage.
  dpram_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .push       (rd_vld_p1),
    .push_data  (ram_q_b),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .skid_count (skid_count)
  );

  assign stream.out_data  = head_data;
  assign stream.out_valid = head_valid;

  a_no_write_when_full : assert property (@(posedge clock) disable iff (reset)
    !(ram_we_a && ram_full));
endmodule

// File: tb/tb_dpram_stream_fifo.sv
// Scoreboard bench for dpram_stream_fifo with a behavioural dual-port RAM attached.
module tb_dpram_stream_fifo;
  import dpram_fifo_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [AW:0]   count;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_q_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic          ram_we_a, ram_we_b;
  logic [DW-1:0] mem [0:(2**AW)-1];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [$];
  logic          stall_p = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int n, cyc, bubbles, in_stalls;

  dpram_stream_fifo_if #(.DATA_WIDTH(DW)) bus ();

  dpram_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .stream     (bus),
    .count      (count),
    .ram_data_a (ram_data_a),
    .ram_addr_a (ram_addr_a),
    .ram_we_a   (ram_we_a),
    .ram_data_b (ram_data_b),
    .ram_addr_b (ram_addr_b),
    .ram_we_b   (ram_we_b),
    .ram_q_b    (ram_q_b)
  );

  always #5 clock = ~clock;

  // Read-before-write dual-port RAM with registered read port
  always @(posedge clock) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Stimulus recorder: accepted input words become expected outputs
  always @(negedge clock) begin
    if (reset || clear) sb.delete();
    else if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
  end

  // Monitor: compares each handshaken output word and checks hold under back-pressure
  always @(negedge clock) begin
    if (!reset && stall_p)
      chk("hold_stable", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, stall_data});
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual=%h required=none", bus.out_data);
      end else begin
        chk("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
      end
    end
    stall_p    <= !reset && !clear && bus.out_valid && !bus.out_ready;
    stall_data <= bus.out_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drain(input string nm);
    int k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && k < 2500) begin
      @(posedge clock);
      k++;
    end
    @(negedge clock);
    chk({nm, "_empty"}, 32'(sb.size()), 32'd0);
    chk({nm, "_count"}, 32'(count), 32'd0);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count",     32'(count), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_we_a",      32'(ram_we_a), 32'd0);
    chk("rst_we_b",      32'(ram_we_b), 32'd0);
    chk("rst_data_b",    32'(ram_data_b), 32'd0);

    // Single word: latency and count profile
    @(posedge clock); #1;
    bus.in_valid = 1'b1; bus.in_data = 16'hA5A5; bus.out_ready = 1'b1;
    @(negedge clock);
    chk("sw_we_a",   32'(ram_we_a), 32'd1);
    chk("sw_addr_a", 32'(ram_addr_a), 32'd0);
    chk("sw_data_a", 32'(ram_data_a), 32'h0000A5A5);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("sw_cnt_e0", 32'(count), 32'd1);
    chk("sw_vld_e0", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk("sw_cnt_e1", 32'(count), 32'd1);
    chk("sw_vld_e1", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    chk("sw_cnt_e2", 32'(count), 32'd1);
    chk("sw_vld_e2", 32'(bus.out_valid), 32'd1);
    @(negedge clock);
    chk("sw_cnt_e3", 32'(count), 32'd0);
    chk("sw_vld_e3", 32'(bus.out_valid), 32'd0);

    // Fill with consumer stalled, then drain in order
    @(posedge clock); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = '0;
    n = 0; cyc = 0;
    while (n < DEPTH + SKID_DEPTH && cyc < 1200) begin
      @(negedge clock);
      if (bus.in_ready) n++;
      @(posedge clock); #1;
      bus.in_data = DW'(n);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("fill_accepted", 32'(n), 32'd1026);
    repeat (2) @(negedge clock);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_count",    32'(count), 32'd1026);
    @(posedge clock); #1;
    bus.in_valid = 1'b1; bus.in_data = 16'hBEEF;
    @(negedge clock);
    chk("full_no_write", 32'(ram_we_a), 32'd0);
    @(posedge clock); #1;
    drain("fill_drain");

    // Streaming at full rate across two pointer wraps
    @(posedge clock); #1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_data = 16'h1000;
    n = 0; bubbles = 0; in_stalls = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (bus.in_ready) n++; else in_stalls++;
      if (c >= 3 && !bus.out_valid) bubbles++;
      @(posedge clock); #1;
      bus.in_data = DW'(16'h1000 + n);
    end
    chk("stream_words",   32'(n), 32'd3000);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_stalls",  32'(in_stalls), 32'd0);
    drain("stream_drain");

    // Random back-pressure on both sides
    n = 0; cyc = 0;
    @(posedge clock); #1;
    while (n < 10000 && cyc < 40000) begin
      bus.in_valid  = ($urandom_range(99) < 70);
      bus.out_ready = ($urandom_range(99) < 50);
      bus.in_data   = DW'($urandom);
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) n++;
      @(posedge clock); #1;
      cyc++;
    end
    chk("bp_words", 32'(n), 32'd10000);
    drain("bp_drain");

    // Clear with five words held and one RAM read in flight
    @(posedge clock); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = DW'(16'hC000 + i);
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 bus.out_ready = 1'b1;
    @(negedge clock);
    chk("pre_clr_count", 32'(count), 32'd6);
    @(posedge clock); #1;
    bus.out_ready = 1'b0; clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
    @(negedge clock);
    chk("clr_cycle_count", 32'(count), 32'd5);
    @(posedge clock); #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    @(negedge clock);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_count",     32'(count), 32'd0);
    @(posedge clock); #1;
    bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    @(negedge clock);
    chk("clr_we_a",   32'(ram_we_a), 32'd1);
    chk("clr_addr_a", 32'(ram_addr_a), 32'd0);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("clr_addr_b", 32'(ram_addr_b), 32'd0);
    @(posedge clock); #1;
    drain("clr_drain");

    // Asynchronous reset in the middle of a stream
    @(posedge clock); #1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_data = DW'(16'h7000 + k);
      @(posedge clock); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_we_a",      32'(ram_we_a), 32'd0);
    chk("arst_count",     32'(count), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b0;
    @(negedge clock);
    chk("arst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("arst_empty_vld", 32'(bus.out_valid), 32'd0);
    chk("arst_empty_cnt", 32'(count), 32'd0);
    @(posedge clock); #1;
    bus.in_valid = 1'b1; bus.in_data = 16'h5A5A;
    @(negedge clock);
    chk("arst_addr_a", 32'(ram_addr_a), 32'd0);
    @(posedge clock); #1;
    drain("arst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
